// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types and byte-index helpers for the decryption datapath
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Column-major byte index: byte k sits at row k mod 4, column k / 4
  function automatic logic [3:0] rc_to_idx(input logic [1:0] row, input logic [1:0] col);
    return {col, row};
  endfunction

  // Source byte for a destination byte under InvShiftRows: row r rotates right by r
  function automatic logic [3:0] inv_shift_src(input logic [3:0] dst);
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] src_col;
    row     = dst[1:0];
    col     = dst[3:2];
    src_col = col - row;
    return rc_to_idx(row, src_col);
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box, 8 bits in, 8 bits out
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/aes_inv_sub_shift.sv
// rtl/aes_inv_sub_shift.sv - sequential AES InvSubBytes + InvShiftRows over a valid/ready handshake
module aes_inv_sub_shift
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

  fsm_e             r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;
  byte_t            r_in_b  [16];
  byte_t            r_res_b [16];

  logic             w_accept;
  logic [3:0]       w_dst      [BYTES_PER_CYCLE];
  byte_t            w_sbox_in  [BYTES_PER_CYCLE];
  byte_t            w_sbox_out [BYTES_PER_CYCLE];

  assign w_accept  = (r_state == IDLE) && in_valid && r_in_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  // Each lane owns one destination byte of the current chunk and pulls its shifted source byte
  always_comb begin
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      w_dst[l]     = 4'(int'(r_cnt) * BYTES_PER_CYCLE + l);
      w_sbox_in[l] = r_in_b[inv_shift_src(w_dst[l])];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    inv_sbox u_inv_sbox (
      .i_byte (w_sbox_in[g]),
      .o_byte (w_sbox_out[g])
    );
  end

  // Control FSM: accept in IDLE, sweep chunks in BUSY, hold result in DONE until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == CNT_LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Input state is captured only on acceptance so the producer may change in_data afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) r_in_b[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < 16; k++) r_in_b[k] <= in_data[127-8*k -: 8];
    end
  end

  // Result bytes for the current chunk are written while BUSY; the rest keep stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) r_res_b[k] <= '0;
    end else if (r_state == BUSY) begin
      for (int l = 0; l < BYTES_PER_CYCLE; l++) r_res_b[w_dst[l]] <= w_sbox_out[l];
    end
  end

  // Pack result bytes back into the FIPS-197 byte order
  always_comb begin
    out_data = '0;
    for (int k = 0; k < 16; k++) out_data[127-8*k -: 8] = r_res_b[k];
  end

endmodule

// File: tb/tb_aes_inv_sub_shift.sv
// tb/tb_aes_inv_sub_shift.sv - directed and round-trip bench for aes_inv_sub_shift
module tb_aes_inv_sub_shift;

  localparam logic [7:0] FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam int N_RT = 1000;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instances 0/1/2 run with 1, 4 and 16 bytes per cycle; directed tests use instance 1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_sub_shift #(.BYTES_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 4 : 16))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  function automatic logic [127:0] fill63();
    return {16{8'h63}};
  endfunction

  function automatic logic [127:0] set_byte(input logic [127:0] v, input int k, input logic [7:0] b);
    logic [127:0] r;
    r = v;
    r[127-8*k -: 8] = b;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Forward SubBytes + ShiftRows: out(r,c) = Sbox(in(r,(c+r) mod 4))
  function automatic logic [127:0] fwd_cipher(input logic [127:0] s);
    logic [127:0] t;
    int r, c, src;
    t = '0;
    for (int k = 0; k < 16; k++) begin
      r   = k % 4;
      c   = k / 4;
      src = ((c + r) % 4) * 4 + r;
      t[127-8*k -: 8] = FWD[s[127-8*src -: 8]];
    end
    return t;
  endfunction

  task automatic run_block(input int d, input logic [127:0] data, output logic [127:0] got, output logic ok);
    int t;
    ok  = 1'b0;
    got = '0;
    t = 0;
    while (!in_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[d]) return;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_data[d]  = rand128();
    t = 0;
    while (!out_valid[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid[d]) return;
    got = out_data[d];
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready[%0d] got=%b exp=0", d, in_ready[d]); end
      n_checks++;
      if (out_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", d, out_valid[d]); end
      n_checks++;
      if (out_data[d] !== 128'h0) begin n_fail++; $display("FAIL reset_out_data[%0d] got=%032h exp=0", d, out_data[d]); end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got=%b exp=1", in_ready[1]); end
    n_checks++;
    if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid got=%b exp=0", out_valid[1]); end
  endtask

  task automatic test_idle_latency();
    int lat;
    in_valid[1] = 1'b1;
    in_data[1]  = fill63();
    @(negedge clk);
    in_valid[1] = 1'b0;
    lat = 0;
    while (!out_valid[1] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL latency got=%0d exp=4", lat); end
    n_checks++;
    if (out_data[1] !== 128'h0) begin n_fail++; $display("FAIL all63 got=%032h exp=0", out_data[1]); end
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    n_checks++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL release got in_ready=%b out_valid=%b exp 1/0", in_ready[1], out_valid[1]);
    end
  endtask

  task automatic test_sweep();
    logic [127:0] got, exp;
    logic ok;
    logic [7:0] sp_in  [5] = '{8'h63, 8'h7c, 8'h16, 8'h00, 8'h52};
    logic [7:0] sp_exp [5] = '{8'h00, 8'h01, 8'hff, 8'h52, 8'h48};
    for (int v = 0; v < 256; v++) begin
      run_block(1, set_byte(fill63(), 0, FWD[v]), got, ok);
      exp = {8'(v), 120'h0};
      n_checks++;
      if (!ok || got !== exp) begin n_fail++; $display("FAIL sweep v=%02h ok=%b got=%032h exp=%032h", v, ok, got, exp); end
    end
    for (int i = 0; i < 5; i++) begin
      run_block(1, set_byte(fill63(), 0, sp_in[i]), got, ok);
      exp = {sp_exp[i], 120'h0};
      n_checks++;
      if (!ok || got !== exp) begin n_fail++; $display("FAIL spot in=%02h ok=%b got=%032h exp=%032h", sp_in[i], ok, got, exp); end
    end
  endtask

  task automatic test_rotation();
    logic [127:0] got, exp;
    logic ok;
    int dst [4] = '{0, 5, 10, 15};
    for (int k = 0; k < 4; k++) begin
      run_block(1, set_byte(fill63(), k, 8'h7c), got, ok);
      exp = set_byte(128'h0, dst[k], 8'h01);
      n_checks++;
      if (!ok || got !== exp) begin n_fail++; $display("FAIL rotation k=%0d ok=%b got=%032h exp=%032h", k, ok, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    int stamps [$];
    in_valid[1]  = 1'b1;
    in_data[1]   = fill63();
    out_ready[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid[1]) begin
        stamps.push_back(c);
        n_checks++;
        if (out_data[1] !== 128'h0) begin n_fail++; $display("FAIL b2b_data got=%032h exp=0", out_data[1]); end
      end
    end
    in_valid[1] = 1'b0;
    repeat (10) @(negedge clk);
    out_ready[1] = 1'b0;
    n_checks++;
    if (stamps.size() < 3) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d exp>=3", stamps.size());
    end else begin
      for (int i = 1; i < stamps.size(); i++) begin
        n_checks++;
        if (stamps[i] - stamps[i-1] != 6) begin n_fail++; $display("FAIL b2b_period got=%0d exp=6", stamps[i] - stamps[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp;
    int t;
    exp = set_byte(128'h0, 15, 8'h01);
    in_valid[1] = 1'b1;
    in_data[1]  = set_byte(fill63(), 3, 8'h7c);
    @(negedge clk);
    in_valid[1] = 1'b0;
    t = 0;
    while (!out_valid[1] && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== exp || in_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold c=%0d got valid=%b ready=%b data=%032h exp 1/0/%032h", c, out_valid[1], in_ready[1], out_data[1], exp);
      end
      in_valid[1] = 1'b1;
      in_data[1]  = rand128();
      @(negedge clk);
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    n_checks++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready[1], out_valid[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got, exp;
    logic ok;
    in_valid[1] = 1'b1;
    in_data[1]  = set_byte(fill63(), 1, 8'h7c);
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b0 || out_data[1] !== 128'h0) begin
      n_fail++;
      $display("FAIL mid_reset got valid=%b ready=%b data=%032h exp 0/0/0", out_valid[1], in_ready[1], out_data[1]);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      n_checks++;
      if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid c=%0d got=%b exp=0", c, out_valid[1]); end
    end
    run_block(1, set_byte(fill63(), 2, 8'h7c), got, ok);
    exp = set_byte(128'h0, 10, 8'h01);
    n_checks++;
    if (!ok || got !== exp) begin n_fail++; $display("FAIL after_reset ok=%b got=%032h exp=%032h", ok, got, exp); end
  endtask

  task automatic test_round_trip(input int d);
    logic [127:0] s, t;
    logic done, seen, r;
    int w, cyc;
    out_ready[d] = 1'b0;
    for (int n = 0; n < N_RT; n++) begin
      s = rand128();
      t = fwd_cipher(s);
      w = 0;
      while (!in_ready[d] && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready[d]) begin
        n_checks++; n_fail++;
        $display("FAIL rt_accept_timeout inst=%0d n=%0d got in_ready=0 exp=1", d, n);
        return;
      end
      in_valid[d] = 1'b1;
      in_data[d]  = t;
      @(negedge clk);
      in_valid[d] = 1'b0;
      in_data[d]  = rand128();
      done = 1'b0;
      seen = 1'b0;
      cyc  = 0;
      while (!done && cyc < 200) begin
        r = 1'($urandom_range(0, 1));
        if (out_valid[d]) begin
          n_checks++;
          if (out_data[d] !== s) begin
            n_fail++;
            $display("FAIL rt inst=%0d n=%0d seen=%b got=%032h exp=%032h", d, n, seen, out_data[d], s);
          end
          seen = 1'b1;
          if (r) done = 1'b1;
        end
        out_ready[d] = r;
        @(negedge clk);
        cyc++;
      end
      out_ready[d] = 1'b0;
      if (!done) begin
        n_checks++; n_fail++;
        $display("FAIL rt_done_timeout inst=%0d n=%0d got done=0 exp=1", d, n);
        return;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_latency();
    test_sweep();
    test_rotation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_round_trip(0);
    test_round_trip(1);
    test_round_trip(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_inv_sub_shift.md
# aes_inv_sub_shift

Sequential AES-128 InvSubBytes + InvShiftRows unit for the decryption datapath. It is the inverse counterpart of the existing forward S-box and SubBytes path. It accepts one 128-bit state over a valid/ready handshake, substitutes BYTES_PER_CYCLE bytes per cycle through the inverse S-box while applying the inverse row rotation, and then presents the result until the consumer takes it. It sits in the inverse round loop between AddRoundKey/InvMixColumns and the round register.

## Interface
Parameters:
- BYTES_PER_CYCLE, 4: inverse S-box instances and bytes processed per cycle. Legal values are 1, 2, 4, 8 and 16. Derived NUM_CHUNKS = 16 / BYTES_PER_CYCLE.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  in_data holds a state to process.
- in_ready  out  1  block can accept a state.
- in_data  in  128  input state.
- out_valid  out  1  out_data holds a completed result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  result state.

## Operation
- Byte layout:
  - Byte k occupies in_data[127-8k -: 8].
  - Byte k is at row r = k mod 4, column c = k / 4 (column-major, FIPS-197 order).
- Function:
  - out byte (r,c) = InvSbox(in byte (r, (c - r) mod 4)).
  - Row r is rotated right by r positions; row 0 is unchanged.
  - Column indices wrap modulo 4, using a 2-bit subtraction.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready, register in_data, clear chunk counter, go to BUSY.
  - BUSY: each cycle, write output bytes cnt*BYTES_PER_CYCLE through cnt*BYTES_PER_CYCLE + BYTES_PER_CYCLE - 1 into the result register, then increment cnt. When cnt = NUM_CHUNKS-1, go to DONE.
  - DONE: out_valid=1 and out_data is stable. On out_ready, go to IDLE.
- Gating and ignored inputs:
  - in_ready=0 in BUSY and DONE; in_data is ignored there.
  - out_ready is ignored outside DONE.
- Chunk counter:
  - Width is clog2(NUM_CHUNKS), minimum 1 bit.
  - It never wraps inside a block.
  - For BYTES_PER_CYCLE=16, BUSY lasts exactly one cycle.
- The input register is written only on acceptance. Result bytes not yet written in the current block retain stale data, which is invisible because out_valid=0.

## Timing
- Reset values: in_ready=0 while rst_n is low, then 1 in IDLE; out_valid=0; out_data=128'h0; counter 0; FSM in IDLE.
- Latency: out_valid rises NUM_CHUNKS rising edges after the accepting edge. This is 4 cycles for the default.
- Back-pressure: out_valid stays high and out_data stays stable until out_ready is sampled high.
- Cycles per block:
  - The cycle in which out_ready is high is the last DONE cycle.
  - in_ready rises on the next cycle; there is no same-cycle output-accept/input-accept overlap.
  - Minimum period per block is NUM_CHUNKS + 2 cycles with out_ready tied high.
- in_valid held high while in_ready=0 has no effect.
- Reset asserted mid-block, in BUSY or DONE:
  - The block is discarded immediately and asynchronously.
  - Outputs take their reset values; no partial result is ever presented.
- in_data is combinationally unused after acceptance, so the producer may change it freely.

## Structure
- Shared aes_pkg:
  - byte_t and state_t typedefs.
  - Row/column-to-byte-index function.
  - Inverse ShiftRows source-index function.
- Sub-module inv_sbox:
  - Purely combinational 8-bit to 8-bit inverse S-box, same port shape as the forward S-box.
  - Instantiated BYTES_PER_CYCLE times.
  - Operand selection: each instance gets a mux over the registered input bytes, indexed by counter and lane.

## Test plan
- Reset and idle:
  - Reset, then check in_ready=1, out_valid=0, out_data=0.
  - Accept a state of all bytes 0x63, wait 4 cycles: out_data = all 0x00.
- Substitution sweep:
  - Drive byte 0 through 0x00..0xFF with other bytes 0x63.
  - Expect out byte 0 = InvSbox value; spot values 0x63→0x00, 0x7c→0x01, 0x16→0xff, 0x00→0x52, 0x52→0x48.
- Row rotation (all other bytes 0x63, so all other outputs 0x00):
  - 0x7c at byte 0 → 0x01 at byte 0.
  - 0x7c at byte 1 → 0x01 at byte 5.
  - 0x7c at byte 2 → 0x01 at byte 10.
  - 0x7c at byte 3 → 0x01 at byte 15.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises: out_data stable, in_ready=0, new in_valid ignored.
  - Release out_ready: in_ready rises on the next cycle.
- Reset mid-operation: assert rst_n low two cycles after acceptance; out_valid stays 0 and the next block's result is correct.
- Round trip:
  - Apply forward ShiftRows+SubBytes to 1000 random states in the bench model, feed the results to the DUT, expect the originals.
  - Run with out_ready randomly toggled, for BYTES_PER_CYCLE = 1, 4 and 16.
